// File: rtl/seq_magnitude_comparator_if.sv
// Operand/result handshake bundle for seq_magnitude_comparator.
// master drives operands and accepts results; slave is the comparator.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             lt;
  logic             gt;

  modport master (
    output in_valid,
    input  in_ready,
    output a,
    output b,
    output is_signed,
    input  out_valid,
    output out_ready,
    input  eq,
    input  lt,
    input  gt
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
    input  is_signed,
    output out_valid,
    input  out_ready,
    output eq,
    output lt,
    output gt
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Chunk-serial eq/lt/gt comparator, MSB chunk first, signed-capable.
// SEQ_CMP_EARLY_EXIT_EN: finish right after the first differing chunk.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                      clk,
  input logic                      rst,
  seq_magnitude_comparator_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] TOP = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic [IW-1:0]    idx;
  logic             decided;
  logic             dlt;
  logic             dgt;

  logic             ov_q;
  logic             eq_q;
  logic             lt_q;
  logic             gt_q;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic             c_lt;
  logic             c_gt;
  logic             fin_lt;
  logic             fin_gt;
  logic             last;
  logic             cmp_end;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = ov_q;
  assign bus.eq        = eq_q;
  assign bus.lt        = lt_q;
  assign bus.gt        = gt_q;

  // Flipping both MSBs of the top chunk maps two's complement onto unsigned order.
  always_comb begin
    ca = a_q[idx*CHUNK +: CHUNK];
    cb = b_q[idx*CHUNK +: CHUNK];
    if (sgn_q && (idx == TOP)) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
    c_lt   = (ca < cb);
    c_gt   = (ca > cb);
    fin_lt = decided ? dlt : c_lt;
    fin_gt = decided ? dgt : c_gt;
    last   = (idx == '0);
  end

`ifdef SEQ_CMP_EARLY_EXIT_EN
  assign cmp_end = last || c_lt || c_gt;
`else
  assign cmp_end = last;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (bus.in_valid) begin
          state_nx = CMP;
        end
      end
      (state == CMP): begin
        if (cmp_end) begin
          state_nx = DONE;
        end
      end
      (state == DONE): begin
        if (bus.out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      idx     <= TOP;
      decided <= 1'b0;
      dlt     <= 1'b0;
      dgt     <= 1'b0;
      ov_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sgn_q   <= bus.is_signed;
            idx     <= TOP;
            decided <= 1'b0;
            dlt     <= 1'b0;
            dgt     <= 1'b0;
          end
        end
        (state == CMP): begin
          if (!decided && (c_lt || c_gt)) begin
            decided <= 1'b1;
            dlt     <= c_lt;
            dgt     <= c_gt;
          end
          if (!last) begin
            idx <= idx - 1'b1;
          end
          if (cmp_end) begin
            ov_q <= 1'b1;
            lt_q <= fin_lt;
            gt_q <= fin_gt;
            eq_q <= ~(fin_lt | fin_gt);
          end
        end
        (state == DONE): begin
          if (bus.out_ready) begin
            ov_q <= 1'b0;
            eq_q <= 1'b0;
            lt_q <= 1'b0;
            gt_q <= 1'b0;
          end
        end
        default: begin
          ov_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator (WIDTH=16, CHUNK=4).
// Honours SEQ_CMP_EARLY_EXIT_EN in its latency model.
module tb_seq_magnitude_comparator;

  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_magnitude_comparator_if #(.WIDTH(W)) bus ();

  seq_magnitude_comparator #(
    .WIDTH(W),
    .CHUNK(C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [2:0] res;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   n_res = 0;
  int   n_exp = 0;
  logic prev_ov = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] model(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic s);
    if (a == b) return 3'b100;
    if (s) return ($signed(a) < $signed(b)) ? 3'b010 : 3'b001;
    return (a < b) ? 3'b010 : 3'b001;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
`ifdef SEQ_CMP_EARLY_EXIT_EN
    for (int j = 1; j <= N; j++) begin
      if (a[(N-j)*C +: C] != b[(N-j)*C +: C]) return j;
    end
`endif
    return N;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      sb.delete();
      prev_ov = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back('{res: model(bus.a, bus.b, bus.is_signed),
                       lat: exp_lat(bus.a, bus.b),
                       acc: cyc + 1});
        last_acc = cyc + 1;
      end
      if (bus.out_valid) begin
        check("busy_rdy", 32'(bus.in_ready), 0);
        if (sb.size() == 0) begin
          check("spurious", 1, 0);
        end else begin
          if (!prev_ov) check("latency", cyc - sb[0].acc, sb[0].lat);
          check("result", {bus.eq, bus.lt, bus.gt}, sb[0].res);
          if (bus.out_ready) begin
            void'(sb.pop_front());
            n_res++;
          end
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s);
    int t = 0;
    while (!bus.in_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) check("rdy_timeout", 0, 1);
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.a         = W'($urandom);
    bus.b         = W'($urandom);
    bus.is_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) check("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic s);
    send(a, b, s);
    n_exp++;
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a1;
    int t;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.is_signed = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ov", 32'(bus.out_valid), 0);
    check("rst_res", {bus.eq, bus.lt, bus.gt}, 0);
    check("rst_rdy", 32'(bus.in_ready), 1);

    op(16'h1234, 16'h1234, 1'b0);
    op(16'h1234, 16'h1235, 1'b0);
    op(16'h8000, 16'h0001, 1'b0);
    op(16'h8000, 16'h0001, 1'b1);
    op(16'h0800, 16'h0000, 1'b1);
    op(16'hFFFF, 16'h8000, 1'b1);

    bus.out_ready = 1'b0;
    send(16'h0F0F, 16'h0F0E, 1'b0);
    n_exp++;
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 50) check("hold_timeout", 0, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
      bus.in_valid = ~bus.in_valid;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
    end
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("hs_ov", 32'(bus.out_valid), 0);
    check("hs_rdy", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    check("no_accept", 32'(bus.in_ready), 1);

    send(16'h1111, 16'h1112, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_rdy", 32'(bus.in_ready), 1);
    check("abort_ov", 32'(bus.out_valid), 0);
    repeat (8) @(posedge clk);
    #1;
    op(16'h00FF, 16'h00FE, 1'b0);

    send(16'hFFFF, 16'h0000, 1'b0);
    a1 = last_acc;
    send(16'hFFFF, 16'h0000, 1'b1);
    check("gap1", last_acc - a1, exp_lat(16'hFFFF, 16'h0000) + 2);
    a1 = last_acc;
    send(16'h7FFF, 16'h7FFF, 1'b0);
    check("gap2", last_acc - a1, exp_lat(16'hFFFF, 16'h0000) + 2);
    n_exp += 3;
    drain();

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = (i % 4 == 0) ? ra : (ra ^ W'(1 << $urandom_range(0, W-1)));
      if (i % 5 == 1) rb = W'($urandom);
      op(ra, rb, 1'($urandom_range(0, 1)));
    end

    check("n_results", n_res, n_exp);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
